dq02abc_scheduler: RTL

DQ02ABC_SCHEDULER -- requirements
Module: dq02abc_scheduler

---
 rtl/dq02abc_scheduler_pkg.sv | 17 +
 rtl/dq02abc_scheduler_rr_arbiter.sv | 45 ++++
 rtl/dq02abc_scheduler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dq02abc_scheduler_pkg.sv
// rtl/dq02abc_scheduler_pkg.sv - shared widths and defaults for the dq0->abc scheduler
`ifndef SINGLE
`define SINGLE 32
`endif

package dq02abc_scheduler_pkg;

  localparam int DQ_NUM_CH  = 4;
  localparam int DQ_LATENCY = 24;
  localparam int DQ_SINGLE  = `SINGLE;

  // Channel id width; never narrower than one bit
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dq02abc_scheduler_rr_arbiter.sv
// rtl/dq02abc_scheduler_rr_arbiter.sv - round-robin one-hot arbiter with internal pointer
module rr_arbiter
  import dq02abc_scheduler_pkg::*;
#(
  parameter int NUM_CH = DQ_NUM_CH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] grant
);

  localparam int IDW = id_width(NUM_CH);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] next_ptr;
  logic [IDW-1:0] scan_idx;
  logic           found;

  // Scan channels starting at the pointer; the first eligible one wins
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    next_ptr = ptr;
    scan_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan_idx = IDW'((int'(ptr) + k) % NUM_CH);
      if (!found && req[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        found           = 1'b1;
        next_ptr        = IDW'((int'(scan_idx) + 1) % NUM_CH);
      end
    end
  end

  // Pointer moves to one past the last winner, so the winner drops to lowest priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else begin
      ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/dq02abc_scheduler.sv
// rtl/dq02abc_scheduler.sv - shares one dq0->abc transform datapath among NUM_CH channels
`ifndef SINGLE
`define SINGLE 32
`endif

module dq02abc_scheduler
  import dq02abc_scheduler_pkg::*;
#(
  parameter int NUM_CH  = DQ_NUM_CH,
  parameter int LATENCY = DQ_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         req,
  input  logic [NUM_CH*`SINGLE-1:0] Vd_bus,
  input  logic [NUM_CH*`SINGLE-1:0] Vq_bus,
  input  logic [NUM_CH*`SINGLE-1:0] sin_bus,
  input  logic [NUM_CH*`SINGLE-1:0] cos_bus,
  output logic [NUM_CH-1:0]         ack,
  output logic [NUM_CH-1:0]         done,
  output logic [NUM_CH*`SINGLE-1:0] Va_bus,
  output logic [NUM_CH*`SINGLE-1:0] Vb_bus,
  output logic [NUM_CH*`SINGLE-1:0] Vc_bus,
  output logic                      dp_sta,
  output logic [`SINGLE-1:0]        dp_Vd,
  output logic [`SINGLE-1:0]        dp_Vq,
  output logic [`SINGLE-1:0]        dp_sin,
  output logic [`SINGLE-1:0]        dp_cos,
  input  logic [`SINGLE-1:0]        dp_Va,
  input  logic [`SINGLE-1:0]        dp_Vb,
  input  logic [`SINGLE-1:0]        dp_Vc,
  input  logic                      dp_done,
  output logic                      tag_err,
  output logic                      busy
);

  localparam int IDW = id_width(NUM_CH);

  logic [NUM_CH-1:0] in_flight;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] exit_mask;
  logic [IDW-1:0]    grant_id;
  logic [IDW-1:0]    issue_id;
  logic              tag_v  [LATENCY];
  logic [IDW-1:0]    tag_id [LATENCY];
  logic              exit_v;
  logic [IDW-1:0]    exit_id;

  // A channel with a transaction outstanding cannot compete again until its result lands
  assign eligible = req & ~in_flight;
  assign exit_v   = tag_v[LATENCY-1];
  assign exit_id  = tag_id[LATENCY-1];
  assign busy     = |in_flight;

  rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (eligible),
    .grant(grant)
  );

  // One-hot grant to channel index
  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) grant_id = IDW'(i);
    end
  end

  // Channel retired by the tag line this cycle
  always_comb begin
    exit_mask = '0;
    if (exit_v) exit_mask[exit_id] = 1'b1;
  end

  // Grant stage: ack pulse, remember the winner, track outstanding channels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack       <= '0;
      issue_id  <= '0;
      in_flight <= '0;
    end else begin
      ack       <= grant;
      if (|grant) issue_id <= grant_id;
      in_flight <= (in_flight | grant) & ~exit_mask;
    end
  end

  // Issue stage: one cycle after the ack, present the winner's operands to the datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_sta <= 1'b0;
      dp_Vd  <= '0;
      dp_Vq  <= '0;
      dp_sin <= '0;
      dp_cos <= '0;
    end else begin
      dp_sta <= |ack;
      if (|ack) begin
        dp_Vd  <= Vd_bus [int'(issue_id)*`SINGLE +: `SINGLE];
        dp_Vq  <= Vq_bus [int'(issue_id)*`SINGLE +: `SINGLE];
        dp_sin <= sin_bus[int'(issue_id)*`SINGLE +: `SINGLE];
        dp_cos <= cos_bus[int'(issue_id)*`SINGLE +: `SINGLE];
      end
    end
  end

  // Tag line mirrors the datapath pipeline so each result is routed to its issuer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_v[i]  <= 1'b0;
        tag_id[i] <= '0;
      end
    end else begin
      tag_v[0]  <= |ack;
      tag_id[0] <= issue_id;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  // Completion: capture results for the retiring tag, and flag datapath/tag disagreement
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done    <= '0;
      Va_bus  <= '0;
      Vb_bus  <= '0;
      Vc_bus  <= '0;
      tag_err <= 1'b0;
    end else begin
      done <= exit_mask;
      if (exit_v) begin
        Va_bus[int'(exit_id)*`SINGLE +: `SINGLE] <= dp_Va;
        Vb_bus[int'(exit_id)*`SINGLE +: `SINGLE] <= dp_Vb;
        Vc_bus[int'(exit_id)*`SINGLE +: `SINGLE] <= dp_Vc;
      end
      if (dp_done != exit_v) tag_err <= 1'b1;
    end
  end

endmodule
